// File: rtl/instr_mem_loader_if.sv
// Load-port and fetch-bus signals of the instruction memory loader.
// master = byte source / CPU side, slave = the memory itself.
interface instr_mem_loader_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic [15:0]         address;
  logic [15:0]         data_out;
  logic [7:0]          ld_byte;
  logic                ld_valid;
  logic                ld_last;
  logic                ld_ready;
  logic                done;
  logic                overflow;
  logic [DEPTH_LOG2:0] word_count;

  modport master (
    output address, ld_byte, ld_valid, ld_last,
    input  data_out, ld_ready, done, overflow, word_count
  );

  modport slave (
    input  address, ld_byte, ld_valid, ld_last,
    output data_out, ld_ready, done, overflow, word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory filled by big-endian byte pairs, then read combinationally
// by the CPU fetch bus once the image is complete.
module instr_mem_loader #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [15:0] FILL       = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_loader_if.slave bus
);
  localparam int unsigned NWORDS = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2+1)'(NWORDS);

  typedef enum logic [1:0] {S_HI, S_LO, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [DEPTH_LOG2:0] wc_q, wc_d;
  logic                ovf_q, ovf_d;
  logic                we;
  logic [15:0]         wdata;
  logic                xfer;
  logic                full;

  logic [15:0] mem [NWORDS];

  assign xfer = bus.ld_valid && bus.ld_ready;
  assign full = (wc_q == CAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HI;
      hi_q    <= 8'h00;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Contents survive reset; word_count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wc_q[DEPTH_LOG2-1:0]] <= wdata;
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wdata   = {hi_q, bus.ld_byte};
    unique case (state_q)
      S_HI: begin
        if (xfer) begin
          if (bus.ld_last) begin
            wdata   = {bus.ld_byte, 8'h00};
            state_d = S_DONE;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              we   = 1'b1;
              wc_d = wc_q + 1'b1;
            end
          end else begin
            hi_d    = bus.ld_byte;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          // A dropped write ends the load even without ld_last.
          if (full) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            we      = 1'b1;
            wc_d    = wc_q + 1'b1;
            state_d = bus.ld_last ? S_DONE : S_HI;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_HI;
    endcase
  end

  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit;

  always_comb begin
    bus.ld_ready   = (state_q != S_DONE);
    bus.done       = (state_q == S_DONE);
    bus.overflow   = ovf_q;
    bus.word_count = wc_q;
    idx            = bus.address[DEPTH_LOG2-1:0];
    hit            = bus.done && (bus.address[15:DEPTH_LOG2] == '0)
                     && ({1'b0, idx} < wc_q);
    bus.data_out   = hit ? mem[idx] : FILL;
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench; expected image derived from the byte list arithmetically.
module tb_instr_mem_loader;
  localparam logic [15:0] FILL_A = 16'hF1F1;
  localparam logic [15:0] FILL_B = 16'h0BAD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.DEPTH_LOG2(8)) ifa();
  instr_mem_loader_if #(.DEPTH_LOG2(2)) ifb();

  instr_mem_loader #(.DEPTH_LOG2(8), .FILL(FILL_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  instr_mem_loader #(.DEPTH_LOG2(2), .FILL(FILL_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int         checks   = 0;
  int         failures = 0;
  int         sel      = 0;
  logic [7:0] byte_q[$];
  bit         last_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [15:0] a);
    ifa.address = a;
    ifb.address = a;
  endtask

  task automatic set_ld(input logic [7:0] b, input logic l, input logic v);
    ifa.ld_byte = b;  ifb.ld_byte = b;
    ifa.ld_last = l;  ifb.ld_last = l;
    ifa.ld_valid = v && (sel == 0);
    ifb.ld_valid = v && (sel == 1);
  endtask

  function automatic logic [31:0] obs_wc();
    return (sel != 0) ? 32'(ifb.word_count) : 32'(ifa.word_count);
  endfunction

  // Reset both DUTs while a byte is offered: reset must win.
  task automatic do_reset();
    rst = 1'b1;
    ifa.ld_valid = 1'b1; ifb.ld_valid = 1'b1;
    ifa.ld_byte = 8'($urandom); ifb.ld_byte = ifa.ld_byte;
    ifa.ld_last = 1'b1; ifb.ld_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_ld(8'h00, 1'b0, 1'b0);
    byte_q.delete();
    last_flag = 1'b0;
  endtask

  // Send byte_q[from..] with random idle gaps carrying junk data.
  task automatic send(input int from, input int max_gap);
    for (int i = from; i < byte_q.size(); i++) begin
      int gaps = int'($urandom_range(max_gap, 0));
      repeat (gaps) begin
        set_ld(8'($urandom), 1'($urandom), 1'b0);
        @(posedge clk); #1;
      end
      set_ld(byte_q[i], last_flag && (i == byte_q.size() - 1), 1'b1);
      @(posedge clk); #1;
      set_ld(8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  // Compare every visible output against what the byte list implies.
  task automatic check_image(input string tag);
    int          n, cap, attempts, cnt, lim;
    bit          ovf, dn;
    logic [15:0] fill, exp, w;
    n        = byte_q.size();
    cap      = (sel != 0) ? 4 : 256;
    fill     = (sel != 0) ? FILL_B : FILL_A;
    attempts = last_flag ? (n + 1) / 2 : n / 2;
    ovf      = attempts > cap;
    cnt      = ovf ? cap : attempts;
    dn       = last_flag || ovf;
    chk({tag, "/word_count"}, obs_wc(), 32'(cnt));
    chk({tag, "/done"}, 32'((sel != 0) ? ifb.done : ifa.done), 32'(dn));
    chk({tag, "/overflow"}, 32'((sel != 0) ? ifb.overflow : ifa.overflow), 32'(ovf));
    chk({tag, "/ld_ready"}, 32'((sel != 0) ? ifb.ld_ready : ifa.ld_ready), 32'(!dn));
    lim = cnt + 3;
    for (int a = 0; a < lim + 4; a++) begin
      logic [15:0] addr;
      addr = (a < lim) ? 16'(a) : 16'($urandom);
      set_addr(addr);
      #1;
      if (dn && int'(addr) < cnt) begin
        w = {byte_q[2*addr], (2*int'(addr) + 1 < n) ? byte_q[2*addr+1] : 8'h00};
        exp = w;
      end else begin
        exp = fill;
      end
      chk($sformatf("%s/dout@%0h", tag, addr),
          32'((sel != 0) ? ifb.data_out : ifa.data_out), 32'(exp));
    end
    set_addr(16'h0000);
  endtask

  task automatic chk_dout(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    set_addr(addr);
    #1;
    chk(tag, 32'((sel != 0) ? ifb.data_out : ifa.data_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    set_addr(16'h0000);
    set_ld(8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    sel = 0;
    check_image("reset");

    // Two-word image from the fetch example.
    byte_q = '{8'h80, 8'h05, 8'h80, 8'h07};
    last_flag = 1'b1;
    send(0, 0);
    check_image("even");
    chk_dout("even/addr0", 16'h0000, 16'h8005);
    chk_dout("even/addr1", 16'h0001, 16'h8007);
    chk_dout("even/addr2", 16'h0002, FILL_A);

    // Odd image gets a zero low byte.
    do_reset();
    byte_q = '{8'h12, 8'h34, 8'h56};
    last_flag = 1'b1;
    send(0, 2);
    check_image("odd");
    chk_dout("odd/addr1", 16'h0001, 16'h5600);

    // Partial image stays hidden, then completes with back-pressure.
    do_reset();
    fill_rand(5);
    send(0, 3);
    check_image("partial");
    fill_rand(2);
    last_flag = 1'b1;
    send(5, 3);
    check_image("partial_done");
    chk_dout("beyond_depth", 16'h0100, FILL_A);
    chk_dout("bit15", 16'h8000, FILL_A);

    // Reset mid-load discards the latched high byte.
    do_reset();
    byte_q = '{8'h01, 8'h02, 8'h03};
    send(0, 1);
    do_reset();
    check_image("midrst");
    byte_q = '{8'hAA, 8'hBB};
    last_flag = 1'b1;
    send(0, 1);
    check_image("after_rst");
    chk_dout("after_rst/addr0", 16'h0000, 16'hAABB);
    chk_dout("after_rst/addr1", 16'h0001, FILL_A);

    // Random images with random gaps.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      fill_rand(int'($urandom_range(40, 1)));
      last_flag = 1'b1;
      send(0, 3);
      check_image($sformatf("rand%0d", it));
    end

    // Exactly full, no overflow.
    do_reset();
    fill_rand(512);
    last_flag = 1'b1;
    send(0, 0);
    check_image("full");

    // Small memory: overflow cases.
    sel = 1;
    do_reset();
    fill_rand(10);
    send(0, 1);
    check_image("ovf10");
    do_reset();
    fill_rand(9);
    last_flag = 1'b1;
    send(0, 1);
    check_image("ovf_odd_last");
    do_reset();
    fill_rand(8);
    last_flag = 1'b1;
    send(0, 1);
    check_image("b_full");
    for (int it = 0; it < 4; it++) begin
      do_reset();
      fill_rand(int'($urandom_range(12, 1)));
      last_flag = 1'($urandom);
      send(0, 2);
      check_image($sformatf("brand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
